// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - ASCII constants, keywords, command codes and helpers for the UART command path
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_BS = 8'h08;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LZ = 8'h7A;
    localparam logic [7:0] CASE_BIT = 8'h20;

    localparam logic [1:0] MODE_WATCH = 2'd0;
    localparam logic [1:0] MODE_DHT   = 2'd1;
    localparam logic [1:0] MODE_SR04  = 2'd2;

    localparam logic [15:0] KW_UP   = "UP";
    localparam logic [15:0] KW_DN   = "DN";
    localparam logic [15:0] KW_WT   = "WT";
    localparam logic [15:0] KW_SR   = "SR";
    localparam logic [23:0] KW_RUN  = "RUN";
    localparam logic [23:0] KW_CLR  = "CLR";
    localparam logic [23:0] KW_DHT  = "DHT";
    localparam logic [31:0] KW_STOP = "STOP";

    typedef enum logic [1:0] {
        S_COLLECT,
        S_DROP,
        S_MATCH
    } state_e;

    typedef enum logic [3:0] {
        CMD_RUN,
        CMD_STOP,
        CMD_CLEAR,
        CMD_UP,
        CMD_DOWN,
        CMD_MODE,
        CMD_TIME,
        CMD_ERR
    } cmd_code_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

    // Two ASCII digits to binary; d*10 is built as d*8 + d*2.
    function automatic logic [7:0] dec_pair(input logic [7:0] hi, input logic [7:0] lo);
        logic [7:0] dh;
        logic [7:0] dl;
        dh = hi - ASCII_0;
        dl = lo - ASCII_0;
        return (dh << 3) + (dh << 1) + dl;
    endfunction

endpackage

// File: rtl/cmd_line_buf.sv
// rtl/cmd_line_buf.sv - line assembly buffer with case folding, backspace and overflow tracking
module cmd_line_buf
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic [MAX_LEN-1:0][7:0] snap_data,
    output logic [LEN_W-1:0]        snap_len,
    output logic                    line_ready,
    output logic                    drop_start,
    output logic                    drop_end
);

    localparam int              IDX_W    = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0][7:0] line_q;
    logic [LEN_W-1:0]        len;
    logic                    overflow;
    logic                    is_term;
    logic                    is_bs;
    logic [7:0]              folded;

    assign is_term = (byte_data == ASCII_CR) || (byte_data == ASCII_LF);
    assign is_bs   = (byte_data == ASCII_BS);
    assign folded  = (byte_data >= ASCII_LA && byte_data <= ASCII_LZ) ? (byte_data & ~CASE_BIT)
                                                                      : byte_data;

    // Strobes describe the byte presented this cycle, so the FSM moves on the same edge.
    assign line_ready = byte_valid && is_term && !overflow && (len != '0);
    assign drop_start = byte_valid && !is_term && !is_bs && !overflow && (len == LEN_FULL);
    assign drop_end   = byte_valid && is_term && overflow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            line_q    <= '0;
            len       <= '0;
            overflow  <= 1'b0;
            snap_data <= '0;
            snap_len  <= '0;
        end else if (byte_valid) begin
            if (overflow) begin
                if (is_term) begin
                    overflow <= 1'b0;
                    len      <= '0;
                end
            end else if (is_term) begin
                if (len != '0) begin
                    snap_data <= line_q;
                    snap_len  <= len;
                    len       <= '0;
                end
            end else if (is_bs) begin
                if (len != '0) begin
                    len <= len - 1'b1;
                end
            end else if (len == LEN_FULL) begin
                overflow <= 1'b1;
            end else begin
                line_q[len[IDX_W-1:0]] <= folded;
                len                    <= len + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - decodes UART RX command lines into command pulses, mode level and set-time values
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       cmd_run,
    output logic       cmd_stop,
    output logic       cmd_clear,
    output logic       cmd_up,
    output logic       cmd_down,
    output logic [1:0] mode_sel,
    output logic       set_time_valid,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       cmd_err
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0][7:0] snap;
    logic [LEN_W-1:0]        snap_len;
    logic                    line_ready;
    logic                    drop_start;
    logic                    drop_end;

    state_e    state;
    state_e    state_n;
    cmd_code_e code;
    logic [1:0] mode_val;
    logic [7:0] hour_v;
    logic [7:0] min_v;
    logic [7:0] sec_v;
    logic       digits_ok;
    logic [15:0] word2;
    logic [23:0] word3;
    logic [31:0] word4;

    logic       run_n;
    logic       stop_n;
    logic       clear_n;
    logic       up_n;
    logic       down_n;
    logic       time_n;
    logic       err_n;
    logic [1:0] mode_n;
    logic [4:0] hour_n;
    logic [5:0] min_n;
    logic [5:0] sec_n;

    cmd_line_buf #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (rx_done),
        .byte_data  (rx_data),
        .snap_data  (snap),
        .snap_len   (snap_len),
        .line_ready (line_ready),
        .drop_start (drop_start),
        .drop_end   (drop_end)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_COLLECT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_COLLECT: begin
                if (line_ready) begin
                    state_n = S_MATCH;
                end else if (drop_start) begin
                    state_n = S_DROP;
                end
            end
            S_DROP: begin
                if (drop_end) begin
                    state_n = S_COLLECT;
                end
            end
            S_MATCH: state_n = S_COLLECT;
            default: state_n = S_COLLECT;
        endcase
    end

    assign word2 = {snap[0], snap[1]};
    assign word3 = {snap[0], snap[1], snap[2]};
    assign word4 = {snap[0], snap[1], snap[2], snap[3]};

    // Matcher: exact length and content; anything unrecognised falls through as an error.
    always_comb begin
        code      = CMD_ERR;
        mode_val  = MODE_WATCH;
        hour_v    = dec_pair(snap[2], snap[3]);
        min_v     = dec_pair(snap[4], snap[5]);
        sec_v     = dec_pair(snap[6], snap[7]);
        digits_ok = is_digit(snap[2]) && is_digit(snap[3]) && is_digit(snap[4])
                 && is_digit(snap[5]) && is_digit(snap[6]) && is_digit(snap[7]);
        if (snap_len == LEN_W'(2)) begin
            if (word2 == KW_UP) begin
                code = CMD_UP;
            end else if (word2 == KW_DN) begin
                code = CMD_DOWN;
            end else if (word2 == KW_WT) begin
                code     = CMD_MODE;
                mode_val = MODE_WATCH;
            end else if (word2 == KW_SR) begin
                code     = CMD_MODE;
                mode_val = MODE_SR04;
            end
        end else if (snap_len == LEN_W'(3)) begin
            if (word3 == KW_RUN) begin
                code = CMD_RUN;
            end else if (word3 == KW_CLR) begin
                code = CMD_CLEAR;
            end else if (word3 == KW_DHT) begin
                code     = CMD_MODE;
                mode_val = MODE_DHT;
            end
        end else if (snap_len == LEN_W'(4)) begin
            if (word4 == KW_STOP) begin
                code = CMD_STOP;
            end
        end else if (snap_len == LEN_W'(8)) begin
            if (snap[0] == ASCII_T && snap[1] == ASCII_EQ && digits_ok
                && hour_v < 8'd24 && min_v < 8'd60 && sec_v < 8'd60) begin
                code = CMD_TIME;
            end
        end
    end

    always_comb begin
        run_n   = 1'b0;
        stop_n  = 1'b0;
        clear_n = 1'b0;
        up_n    = 1'b0;
        down_n  = 1'b0;
        time_n  = 1'b0;
        err_n   = 1'b0;
        mode_n  = mode_sel;
        hour_n  = set_hour;
        min_n   = set_min;
        sec_n   = set_sec;
        if (state == S_MATCH) begin
            case (code)
                CMD_RUN:   run_n   = 1'b1;
                CMD_STOP:  stop_n  = 1'b1;
                CMD_CLEAR: clear_n = 1'b1;
                CMD_UP:    up_n    = 1'b1;
                CMD_DOWN:  down_n  = 1'b1;
                CMD_MODE:  mode_n  = mode_val;
                CMD_TIME: begin
                    time_n = 1'b1;
                    hour_n = hour_v[4:0];
                    min_n  = min_v[5:0];
                    sec_n  = sec_v[5:0];
                end
                default:   err_n   = 1'b1;
            endcase
        end else if (state == S_DROP && drop_end) begin
            err_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_run        <= 1'b0;
            cmd_stop       <= 1'b0;
            cmd_clear      <= 1'b0;
            cmd_up         <= 1'b0;
            cmd_down       <= 1'b0;
            set_time_valid <= 1'b0;
            cmd_err        <= 1'b0;
            mode_sel       <= MODE_WATCH;
            set_hour       <= '0;
            set_min        <= '0;
            set_sec        <= '0;
        end else begin
            cmd_run        <= run_n;
            cmd_stop       <= stop_n;
            cmd_clear      <= clear_n;
            cmd_up         <= up_n;
            cmd_down       <= down_n;
            set_time_valid <= time_n;
            cmd_err        <= err_n;
            mode_sel       <= mode_n;
            set_hour       <= hour_n;
            set_min        <= min_n;
            set_sec        <= sec_n;
        end
    end

endmodule
